// File: rtl/ddr_wr_buffer_pkg.sv
// Shared definitions for the DDR write/read staging buffers:
// one-hot burst FSM encodings and RGB565 pixel layout.
package ddr_wr_buffer_pkg;

  localparam logic [2:0] IDLE  = 3'b001;
  localparam logic [2:0] JUDGE = 3'b010;
  localparam logic [2:0] WR    = 3'b100;

  localparam int RED_W   = 5;
  localparam int GREEN_W = 6;
  localparam int BLUE_W  = 5;
  localparam int PIX_W   = RED_W + GREEN_W + BLUE_W;
  localparam int WORD_W  = 128;

endpackage

// File: rtl/sfifo_128xN.sv
// Synchronous 128-bit FIFO with registered read data and an occupancy count.
// A read while full frees the slot for a write in the same cycle.
module sfifo_128xN
  import ddr_wr_buffer_pkg::*;
#(
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              wrclk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rd_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic [WORD_W-1:0] rd_data_r;
  logic              wr_acc_s;
  logic              rd_acc_s;

  assign full     = (count_r == (AW+1)'(DEPTH));
  assign empty    = (count_r == '0);
  assign rd_acc_s = rd_en && !empty;
  assign wr_acc_s = wr_en && (!full || rd_acc_s);
  assign count    = count_r;
  assign rd_data  = rd_data_r;

  // Storage array; contents are not reset, only the pointers are.
  always_ff @(posedge wrclk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and registered read port.
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      rd_data_r <= '0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (rd_acc_s) begin
        rd_ptr_r  <= rd_ptr_r + AW'(1'b1);
        rd_data_r <= mem_r[rd_ptr_r];
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ddr_wr_buffer.sv
// Packs RGB565 pixels eight-per-word into a FIFO and requests a DDR write
// burst whenever a full burst of words is stored.
module ddr_wr_buffer
  import ddr_wr_buffer_pkg::*;
#(
  parameter  int BURST_LEN  = 64,
  parameter  int FIFO_DEPTH = 512,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              wrclk,
  input  logic              rst_n,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              wr_start,
  input  logic              wr_data_req,
  output logic [WORD_W-1:0] wr_data,
  input  logic              user_wr_end,
  output logic [CW-1:0]     fifo_count,
  output logic              overflow,
  output logic              sof_err
);

  logic [2:0]        pix_idx_r;
  logic [111:0]      shift_r;
  logic              pack_we_r;
  logic [WORD_W-1:0] pack_word_r;
  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic              start_nxt_s;
  logic              wr_start_r;
  logic              overflow_r;
  logic              sof_err_r;
  logic              word_done_s;
  logic              fifo_rd_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CW-1:0]     fifo_count_s;

  assign word_done_s = pix_valid && !pix_sof && (pix_idx_r == 3'd7);
  assign fifo_rd_s   = wr_data_req && !fifo_empty_s;

  sfifo_128xN #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .wrclk   (wrclk),
    .rst_n   (rst_n),
    .wr_en   (pack_we_r),
    .wr_data (pack_word_r),
    .rd_en   (fifo_rd_s),
    .rd_data (wr_data),
    .count   (fifo_count_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Packer: earlier pixels shift toward the MSB so pixel 0 lands in [127:112].
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_idx_r   <= 3'd0;
      shift_r     <= '0;
      pack_we_r   <= 1'b0;
      pack_word_r <= '0;
    end else begin
      pack_we_r <= word_done_s;
      if (pix_valid) begin
        shift_r   <= {shift_r[95:0], pix_data};
        pix_idx_r <= pix_sof ? 3'd1 : pix_idx_r + 3'd1;
      end
      if (word_done_s) begin
        pack_word_r <= {shift_r, pix_data};
      end
    end
  end

  // Sticky error flags; a full FIFO drops the word unless a read frees a slot.
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
      sof_err_r  <= 1'b0;
    end else begin
      if (pack_we_r && fifo_full_s && !fifo_rd_s) begin
        overflow_r <= 1'b1;
      end
      if (pix_valid && pix_sof && (pix_idx_r != 3'd0)) begin
        sof_err_r <= 1'b1;
      end
    end
  end

  // Burst FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    start_nxt_s = 1'b0;
    case (state_r)
      IDLE: state_nxt_s = JUDGE;
      JUDGE: begin
        if (fifo_count_s >= CW'(BURST_LEN)) begin
          state_nxt_s = WR;
          start_nxt_s = 1'b1;
        end else begin
          state_nxt_s = JUDGE;
        end
      end
      WR: begin
        if (user_wr_end) begin
          state_nxt_s = JUDGE;
        end else begin
          state_nxt_s = WR;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Burst FSM state and registered start pulse.
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      wr_start_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wr_start_r <= start_nxt_s;
    end
  end

  assign wr_start   = wr_start_r;
  assign fifo_count = fifo_count_s;
  assign overflow   = overflow_r;
  assign sof_err    = sof_err_r;

endmodule

// File: tb/tb_ddr_wr_buffer.sv
// Self-checking bench for ddr_wr_buffer: a pixel-packing model feeds a word
// scoreboard that is consumed as the DDR side pulls data.
module tb_ddr_wr_buffer;
  localparam int BURST_LEN  = 64;
  localparam int FIFO_DEPTH = 512;

  logic         wrclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pix_valid = 1'b0;
  logic         pix_sof = 1'b0;
  logic [15:0]  pix_data = 16'h0000;
  logic         wr_start;
  logic         wr_data_req = 1'b0;
  logic [127:0] wr_data;
  logic         user_wr_end = 1'b0;
  logic [9:0]   fifo_count;
  logic         overflow;
  logic         sof_err;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;

  logic [127:0] exp_q[$];
  int           m_cnt = 0;
  int           m_idx = 0;
  logic [127:0] m_word = '0;
  logic         m_ovf = 1'b0;
  logic         m_sof = 1'b0;

  ddr_wr_buffer #(.BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .wrclk       (wrclk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_data    (pix_data),
    .wr_start    (wr_start),
    .wr_data_req (wr_data_req),
    .wr_data     (wr_data),
    .user_wr_end (user_wr_end),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .sof_err     (sof_err)
  );

  always #5 wrclk = ~wrclk;

  always @(negedge wrclk) begin
    if (wr_start === 1'b1) start_cnt++;
  end

  task automatic cyc();
    @(posedge wrclk);
    #1;
  endtask

  // Drive one pixel for one cycle and update the packing model.
  task automatic send_pix(input logic [15:0] d, input logic sof);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    m_word = {m_word[111:0], d};
    if (sof) begin
      if (m_idx != 0) m_sof = 1'b1;
      m_idx = 1;
    end else if (m_idx == 7) begin
      m_idx = 0;
      if (m_cnt < FIFO_DEPTH) begin
        exp_q.push_back(m_word);
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end else begin
      m_idx++;
    end
    cyc();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic pull_word(output logic [127:0] got, input bit keep);
    wr_data_req = 1'b1;
    cyc();
    got = wr_data;
    wr_data_req = keep;
  endtask

  function automatic logic [127:0] pop_exp();
    if (exp_q.size() == 0) return {128{1'bx}};
    m_cnt--;
    return exp_q.pop_front();
  endfunction

  task automatic pulse_wr_end();
    user_wr_end = 1'b1;
    cyc();
    user_wr_end = 1'b0;
  endtask

  task automatic wait_start(input int prev, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      cyc();
      if (start_cnt != prev) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    n_cmp++; if (wr_start !== 1'b0) begin n_err++; $display("FAIL reset_wr_start got %b want 0", wr_start); end
    n_cmp++; if (wr_data !== 128'h0) begin n_err++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    n_cmp++; if (fifo_count !== 10'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    n_cmp++; if ({overflow, sof_err} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {overflow, sof_err}); end
    n_cmp++; if (dut.state_r !== 3'b001) begin n_err++; $display("FAIL reset_state got %b want 001", dut.state_r); end
    rst_n = 1'b1;
    repeat (2) cyc();
    n_cmp++; if (dut.state_r !== 3'b010) begin n_err++; $display("FAIL judge_state got %b want 010", dut.state_r); end
  endtask

  task automatic test_fill_burst();
    for (int i = 0; i < 512; i++) send_pix(i[15:0], 1'b0);
    repeat (4) cyc();
    n_cmp++; if (fifo_count !== 10'd64) begin n_err++; $display("FAIL fill_count got %0d want 64", fifo_count); end
    n_cmp++; if (start_cnt !== 1) begin n_err++; $display("FAIL fill_start_pulses got %0d want 1", start_cnt); end
  endtask

  task automatic test_drain_burst();
    logic [127:0] got, e, w0;
    w0 = '0;
    for (int k = 0; k < 8; k++) w0 = {w0[111:0], k[15:0]};
    for (int i = 0; i < 64; i++) begin
      pull_word(got, i < 63);
      e = pop_exp();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL drain_word%0d got %h want %h", i, got, e); end
      if (i == 0) begin
        n_cmp++; if (got !== w0) begin n_err++; $display("FAIL first_word got %h want %h", got, w0); end
      end
    end
    pulse_wr_end();
    repeat (4) cyc();
    n_cmp++; if (fifo_count !== 10'd0) begin n_err++; $display("FAIL drain_count got %0d want 0", fifo_count); end
    n_cmp++; if (start_cnt !== 1) begin n_err++; $display("FAIL drain_no_restart got %0d want 1", start_cnt); end
  endtask

  task automatic test_sof();
    logic [127:0] got, e, ws;
    for (int k = 0; k < 3; k++) send_pix(16'hA000 + k[15:0], 1'b0);
    send_pix(16'hB000, 1'b1);
    for (int k = 1; k < 8; k++) send_pix(16'hB000 + k[15:0], 1'b0);
    repeat (3) cyc();
    ws = '0;
    for (int k = 0; k < 8; k++) ws = {ws[111:0], 16'hB000 + k[15:0]};
    n_cmp++; if (sof_err !== m_sof) begin n_err++; $display("FAIL sof_err got %b want %b", sof_err, m_sof); end
    n_cmp++; if (fifo_count !== 10'd1) begin n_err++; $display("FAIL sof_count got %0d want 1", fifo_count); end
    pull_word(got, 1'b0);
    e = pop_exp();
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL sof_word got %h want %h", got, e); end
    n_cmp++; if (got !== ws) begin n_err++; $display("FAIL sof_word_const got %h want %h", got, ws); end
  endtask

  task automatic test_overflow();
    logic [127:0] got, e, last;
    int prev;
    prev = start_cnt;
    for (int i = 0; i < 8 * 513; i++) send_pix(16'(i * 3), 1'b0);
    repeat (4) cyc();
    n_cmp++; if (fifo_count !== 10'd512) begin n_err++; $display("FAIL ovf_count got %0d want 512", fifo_count); end
    n_cmp++; if (overflow !== m_ovf) begin n_err++; $display("FAIL ovf_flag got %b want %b", overflow, m_ovf); end
    n_cmp++; if (start_cnt !== prev + 1) begin n_err++; $display("FAIL ovf_start got %0d want %0d", start_cnt, prev + 1); end
    last = '0;
    for (int i = 0; i < 512; i++) begin
      pull_word(got, i < 511);
      e = pop_exp();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL ovf_word%0d got %h want %h", i, got, e); end
      last = got;
    end
    pull_word(got, 1'b0);
    n_cmp++; if (got !== last) begin n_err++; $display("FAIL empty_hold got %h want %h", got, last); end
    n_cmp++; if (fifo_count !== 10'd0) begin n_err++; $display("FAIL ovf_empty_count got %0d want 0", fifo_count); end
    pulse_wr_end();
    repeat (2) cyc();
  endtask

  task automatic test_simul_rw();
    logic [127:0] got, e;
    for (int k = 0; k < 8; k++) send_pix(16'hC000 + k[15:0], 1'b0);
    repeat (2) cyc();
    n_cmp++; if (fifo_count !== 10'd1) begin n_err++; $display("FAIL simul_pre_count got %0d want 1", fifo_count); end
    for (int k = 0; k < 8; k++) send_pix(16'hD000 + k[15:0], 1'b0);
    pull_word(got, 1'b0);
    e = pop_exp();
    n_cmp++; if (fifo_count !== 10'd1) begin n_err++; $display("FAIL simul_count got %0d want 1", fifo_count); end
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL simul_word0 got %h want %h", got, e); end
    pull_word(got, 1'b0);
    e = pop_exp();
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL simul_word1 got %h want %h", got, e); end
  endtask

  task automatic test_reset_mid_burst();
    logic [127:0] got, e;
    bit ok;
    int prev;
    prev = start_cnt;
    for (int i = 0; i < 512; i++) send_pix(16'hE000 ^ i[15:0], 1'b0);
    wait_start(prev, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL mid_start timeout got 0 want 1"); end
    for (int i = 0; i < 20; i++) begin
      pull_word(got, 1'b1);
      e = pop_exp();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL mid_word%0d got %h want %h", i, got, e); end
    end
    #2 rst_n = 1'b0;
    wr_data_req = 1'b0;
    #1;
    n_cmp++; if ({wr_start, overflow, sof_err} !== 3'b000) begin n_err++; $display("FAIL mid_rst_flags got %b want 000", {wr_start, overflow, sof_err}); end
    n_cmp++; if (wr_data !== 128'h0) begin n_err++; $display("FAIL mid_rst_data got %h want 0", wr_data); end
    n_cmp++; if (fifo_count !== 10'd0) begin n_err++; $display("FAIL mid_rst_count got %0d want 0", fifo_count); end
    n_cmp++; if (dut.state_r !== 3'b001) begin n_err++; $display("FAIL mid_rst_state got %b want 001", dut.state_r); end
    exp_q.delete();
    m_cnt = 0; m_idx = 0; m_ovf = 1'b0; m_sof = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    prev = start_cnt;
    for (int i = 0; i < 504; i++) send_pix(16'h7000 + i[15:0], 1'b0);
    repeat (6) cyc();
    n_cmp++; if (start_cnt !== prev) begin n_err++; $display("FAIL mid_early_start got %0d want %0d", start_cnt, prev); end
    n_cmp++; if (fifo_count !== 10'd63) begin n_err++; $display("FAIL mid_count63 got %0d want 63", fifo_count); end
    for (int i = 504; i < 512; i++) send_pix(16'h7000 + i[15:0], 1'b0);
    wait_start(prev, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL mid_restart timeout got 0 want 1"); end
    for (int i = 0; i < 64; i++) begin
      pull_word(got, i < 63);
      e = pop_exp();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL post_word%0d got %h want %h", i, got, e); end
    end
    pulse_wr_end();
    repeat (2) cyc();
  endtask

  initial begin
    test_reset();
    test_fill_burst();
    test_drain_burst();
    test_sof();
    test_overflow();
    test_simul_rw();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_wr_buffer.md
# ddr_wr_buffer

Write-side staging buffer between the incoming pixel stream and the DDR write master; the counterpart of the HDMI read-side buffer. It packs 16-bit RGB565 pixels into 128-bit words and stores them in a synchronous FIFO. When a full burst is stored, it requests a DDR write burst and supplies the words as the DDR write master pulls them. Everything runs in the DDR user clock domain; upstream has already crossed the pixel stream into it.

## Interface
Parameters:
- BURST_LEN, 64: 128-bit words per DDR write burst; must be ≤ FIFO_DEPTH/2.
- FIFO_DEPTH, 512: FIFO depth in 128-bit words; power of two.

Ports:
- wrclk  in  1  DDR user clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pixel qualifier.
- pix_sof  in  1  start of frame; meaningful only with pix_valid.
- pix_data  in  16  RGB565 pixel {red[4:0], green[5:0], blue[4:0]}.
- wr_start  out  1  one-cycle pulse requesting a write burst of BURST_LEN words.
- wr_data_req  in  1  DDR master pulls one word.
- wr_data  out  128  word for the preceding wr_data_req.
- user_wr_end  in  1  one-cycle pulse: burst finished.
- fifo_count  out  log2(FIFO_DEPTH)+1  stored words.
- overflow  out  1  sticky: a packed word was dropped because the FIFO was full.
- sof_err  out  1  sticky: pix_sof arrived with a partial word pending.

## Operation
- Packer:
  - 3-bit pixel index and 128-bit shift register.
  - Pixel 0 of each word occupies [127:112]; pixel 7 occupies [15:0]. This matches the MSB-first unpacking on the read side.
  - On the 8th valid pixel (index 7), the completed word is written to the FIFO and the index wraps to 0.
- pix_sof with pix_valid:
  - The pixel becomes pixel 0 of a new word.
  - If the index was non-zero, the partial word is discarded and sof_err is set.
- FIFO full when a packed word completes: the word is dropped, overflow is set, and FIFO contents are unaffected.
- FSM states (one-hot):
  - IDLE → JUDGE: unconditionally, the cycle after reset release.
  - JUDGE → WR: when fifo_count ≥ BURST_LEN. wr_start pulses high for exactly that transition cycle.
  - WR → JUDGE: on user_wr_end.
  - Illegal encoding → IDLE.
- wr_start never asserts outside the JUDGE→WR transition, so there is at most one outstanding burst.
- wr_data_req:
  - Honoured in any state.
  - Request while the FIFO is empty: ignored, wr_data holds its value, fifo_count stays 0.
- Simultaneous FIFO write and read in the same cycle: fifo_count is unchanged; when full, the read frees the slot and the write is accepted.
- Sticky flags clear only on reset.

## Timing
- Reset values: wr_start 0, wr_data 0, fifo_count 0, overflow 0, sof_err 0, state IDLE, packer index 0.
- Pack latency: the 8th pixel sampled at edge N is counted in fifo_count after edge N+1.
- Read latency: wr_data_req at edge N gives wr_data valid after edge N+1, held until the next accepted request. The DDR master may assert wr_data_req back-to-back.
- wr_start: registered. Asserts the cycle after fifo_count first reads ≥ BURST_LEN while in JUDGE.
- After user_wr_end: earliest next wr_start is two cycles later (WR→JUDGE, then JUDGE→WR).
- Reset asserted mid-burst: all state clears asynchronously and FIFO contents are lost. The DDR master must also be reset.

## Structure
- Shared package/header: one-hot state constants IDLE=3'b001, JUDGE=3'b010, WR=3'b100, and the RGB565 field widths (5/6/5). These are shared with the read-side buffer.
- One sub-module: sfifo_128xN, a synchronous FIFO (DEPTH parameter, 1-cycle registered read, count output, full/empty).
- The packer, FSM and flags live in the top level.

## Test plan
- Reset release, then 512 pixels 0x0000..0x01FF: fifo_count reaches 64; wr_start pulses once. The first word pulled is {16'h0000, 16'h0001, …, 16'h0007}.
- With the burst open, pull 64 words back-to-back with wr_data_req and pulse user_wr_end: data is in order with 1-cycle latency, fifo_count returns to 0, and there is no second wr_start.
- pix_sof on the 4th pixel of a word: sof_err=1. The next completed word starts with the sof pixel, and the 3 earlier pixels never appear.
- Never pull, and push 8×513 pixels: fifo_count saturates at 512 and overflow=1. On the later drain, word 512 is intact and word 513 is absent.
- Push 8 pixels and wr_data_req in the same cycle as a pending word while the FIFO holds 1 word: fifo_count stays 1 and the data order is preserved.
- Drop rst_n mid-burst, 20 words into the drain: all outputs are 0 immediately, the FSM is back in IDLE, and after release the next burst needs 64 new words.
